pipelined_signed_divider: RTL and testbench
===========================================

PIPELINED_SIGNED_DIVIDER -- requirements
Module: pipelined_signed_divider

Interface
REQ-001 Parameter DIVIDEND_W, default 16: dividend and quotient width in bits, legal range 4..32.
REQ-002 Parameter DIVISOR_W, default 8: divisor and remainder width in bits, legal range 2..DIVIDEND_W.
REQ-003 Parameter TAG_W, default 4: width of the user tag carried alongside each operation, minimum 1.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  operands presented this cycle.
REQ-007 signed_mode  input  1  1: both operands two's complement; 0: both unsigned; sampled with in_valid.
REQ-008 dividend  input  DIVIDEND_W  numerator.
REQ-009 divisor  input  DIVISOR_W  denominator.
REQ-010 in_tag  input  TAG_W  opaque tag, returned unchanged with the result.
REQ-011 out_valid  output  1  result fields are valid this cycle.
REQ-012 quotient  output  DIVIDEND_W  quotient.
REQ-013 remainder  output  DIVISOR_W  remainder.
REQ-014 out_tag  output  TAG_W  tag of the operation now on the outputs.
REQ-015 div_by_zero  output  1  the operation had divisor == 0.
REQ-016 overflow  output  1  signed most-negative dividend divided by -1.

Function
REQ-017 The pipeline shall accept one operation on every cycle that in_valid is high, with no backpressure and no stall input.
REQ-018 Latency shall be exactly LATENCY = DIVIDEND_W + 2 rising edges: 1 input/sign-conversion stage, DIVIDEND_W restoring-division stages, and 1 output/sign-fix stage.
REQ-019 Results shall emerge in issue order; out_valid shall be in_valid delayed by LATENCY cycles.
REQ-020 Signed mode: the divider shall divide magnitudes, truncate toward zero, give the quotient a negative sign iff the operand signs differ, and give the remainder the sign of the dividend (dividend = q*divisor + r).
REQ-021 Unsigned mode: the divider shall produce q = floor(dividend/divisor) and r = dividend mod divisor.
REQ-022 Each restoring-division stage shall compare with a subtraction one bit wider than the partial remainder, using the borrow bit as the sign; no magnitude may wrap.
REQ-023 Magnitude of the most-negative dividend (e.g. -128 at 8 bits) shall be handled as unsigned 2^(DIVIDEND_W-1).
REQ-024 Divisor == 0: the outputs shall be quotient all ones, remainder 0, div_by_zero = 1, overflow = 0.
REQ-025 Signed-mode most-negative dividend divided by -1: the outputs shall be quotient = most-negative value, remainder 0, overflow = 1.
REQ-026 div_by_zero, overflow, signed_mode, sign flags and tag shall travel through the pipeline per operation, so each result is independent of neighbouring operations.
REQ-027 When out_valid is 0, the data outputs shall hold their previous values, and div_by_zero and overflow shall be 0.

Reset
REQ-028 Asserting reset shall immediately clear every stage's valid bit and drive out_valid, div_by_zero and overflow to 0, with no clock required.
REQ-029 Asserting reset shall drive quotient, remainder and out_tag to 0.
REQ-030 Operations in flight when reset asserts shall be discarded and never appear on the outputs.
REQ-031 The first in_valid sampled on the first rising edge after reset deasserts shall be accepted.

Structure
REQ-032 A shared package pipelined_divider_pkg shall hold the default widths and the LATENCY expression, for use by instantiating blocks and the bench.
REQ-033 One sub-module divider_stage shall implement a single restoring-division step (partial remainder, divisor, quotient bits, side-band flags and tag in; registered versions out), instantiated DIVIDEND_W times through a generate loop.

Verification (DIVIDEND_W=8, DIVISOR_W=4, LATENCY=10)
REQ-034 Unsigned 200/7 -> q=28 (0x1C), r=4, flags 0, exactly 10 cycles after issue.
REQ-035 Signed -17/2 -> q=-8 (0xF8), r=-1 (0xF); signed 17/-3 -> q=-5 (0xFB), r=2.
REQ-036 Signed -128/-1 -> q=0x80, r=0, overflow=1; unsigned 0x80/0xF -> q=8, r=8, overflow=0.
REQ-037 Any dividend, divisor 0 (either mode) -> q=0xFF, r=0, div_by_zero=1.
REQ-038 Issue 12 back-to-back random operations with mixed modes and tags 0..11 -> 12 consecutive out_valid cycles with tags in order, each result matching a reference model.
REQ-039 Assert reset for 1 cycle after issuing 5 operations, then issue 1 more -> out_valid drops immediately, none of the 5 emerge, and the new operation emerges alone LATENCY cycles later.

Source files
------------

// File: rtl/pipelined_signed_divider_pkg.sv
// Shared widths, latency and side-band types for the pipelined signed divider.
package pipelined_divider_pkg;

  localparam int DEFAULT_DIVIDEND_W = 16;
  localparam int DEFAULT_DIVISOR_W  = 8;
  localparam int DEFAULT_TAG_W      = 4;

  // Input stage + one stage per quotient bit + output stage.
  function automatic int latency_of(input int dividend_w);
    return dividend_w + 2;
  endfunction

  localparam int LATENCY = DEFAULT_DIVIDEND_W + 2;

  typedef struct packed {
    logic signed_mode;
    logic neg_q;
    logic neg_r;
    logic div_by_zero;
    logic overflow;
  } side_t;

endpackage

// File: rtl/pipelined_signed_divider_if.sv
// Operand/result bundle between an issuing block and the pipelined divider.
interface pipelined_signed_divider_if #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8,
  parameter int TAG_W      = 4
);
  logic                  in_valid;
  logic                  signed_mode;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic [TAG_W-1:0]      in_tag;
  logic                  out_valid;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic [TAG_W-1:0]      out_tag;
  logic                  div_by_zero;
  logic                  overflow;

  modport master (
    output in_valid, signed_mode, dividend, divisor, in_tag,
    input  out_valid, quotient, remainder, out_tag, div_by_zero, overflow
  );

  modport slave (
    input  in_valid, signed_mode, dividend, divisor, in_tag,
    output out_valid, quotient, remainder, out_tag, div_by_zero, overflow
  );
endinterface

// File: rtl/pipelined_signed_divider_stage.sv
// One registered restoring-division step: produces one quotient bit per cycle.
module divider_stage
  import pipelined_divider_pkg::*;
#(
  parameter int DIVIDEND_W = DEFAULT_DIVIDEND_W,
  parameter int DIVISOR_W  = DEFAULT_DIVISOR_W,
  parameter int TAG_W      = DEFAULT_TAG_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  vld_in,
  input  logic [DIVISOR_W-1:0]  rem_in,
  input  logic [DIVISOR_W-1:0]  dvs_in,
  input  logic [DIVIDEND_W-1:0] acc_in,
  input  side_t                 side_in,
  input  logic [TAG_W-1:0]      tag_in,
  output logic                  vld_out,
  output logic [DIVISOR_W-1:0]  rem_out,
  output logic [DIVISOR_W-1:0]  dvs_out,
  output logic [DIVIDEND_W-1:0] acc_out,
  output side_t                 side_out,
  output logic [TAG_W-1:0]      tag_out
);

  logic [DIVISOR_W:0]   shifted;
  logic [DIVISOR_W+1:0] trial;
  logic                 borrow;
  logic                 unused_trial_msb;

  // acc holds the unconsumed dividend bits on top and the quotient bits
  // produced so far underneath; the trial subtraction is one bit wider than
  // the shifted remainder so its top bit is a clean borrow.
  always_comb begin
    shifted = {rem_in, acc_in[DIVIDEND_W-1]};
    trial   = {1'b0, shifted} - {2'b00, dvs_in};
    borrow  = trial[DIVISOR_W+1];
  end

  assign unused_trial_msb = trial[DIVISOR_W];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) vld_out <= 1'b0;
    else       vld_out <= vld_in;
  end

  always_ff @(posedge clock) begin
    rem_out  <= borrow ? shifted[DIVISOR_W-1:0] : trial[DIVISOR_W-1:0];
    acc_out  <= {acc_in[DIVIDEND_W-2:0], ~borrow};
    dvs_out  <= dvs_in;
    side_out <= side_in;
    tag_out  <= tag_in;
  end

endmodule

// File: rtl/pipelined_signed_divider.sv
// Fully pipelined signed/unsigned restoring divider, one operation per clock,
// latency DIVIDEND_W + 2.
module pipelined_signed_divider
  import pipelined_divider_pkg::*;
#(
  parameter int DIVIDEND_W = DEFAULT_DIVIDEND_W,
  parameter int DIVISOR_W  = DEFAULT_DIVISOR_W,
  parameter int TAG_W      = DEFAULT_TAG_W
) (
  input logic                       clock,
  input logic                       reset,
  pipelined_signed_divider_if.slave bus
);

  localparam logic [DIVIDEND_W-1:0] MOST_NEG = {1'b1, {(DIVIDEND_W-1){1'b0}}};

  function automatic logic [DIVIDEND_W-1:0] fix_dividend(input logic [DIVIDEND_W-1:0] v,
                                                         input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [DIVISOR_W-1:0] fix_divisor(input logic [DIVISOR_W-1:0] v,
                                                       input logic neg);
    return neg ? -v : v;
  endfunction

  logic  dvd_neg, dvs_neg;
  side_t side_in;

  always_comb begin
    dvd_neg             = bus.signed_mode & bus.dividend[DIVIDEND_W-1];
    dvs_neg             = bus.signed_mode & bus.divisor[DIVISOR_W-1];
    side_in.signed_mode = bus.signed_mode;
    side_in.neg_q       = dvd_neg ^ dvs_neg;
    side_in.neg_r       = dvd_neg;
    side_in.div_by_zero = (bus.divisor == '0);
    side_in.overflow    = bus.signed_mode & (bus.dividend == MOST_NEG) & (bus.divisor == '1);
  end

  // ---- p0: sign conversion to magnitudes ----
  logic                  vld_p0;
  logic [DIVIDEND_W-1:0] acc_p0;
  logic [DIVISOR_W-1:0]  dvs_p0;
  side_t                 side_p0;
  logic [TAG_W-1:0]      tag_p0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) vld_p0 <= 1'b0;
    else       vld_p0 <= bus.in_valid;
  end

  // The most-negative dividend negates to itself, which read unsigned is 2^(W-1).
  always_ff @(posedge clock) begin
    acc_p0  <= fix_dividend(bus.dividend, dvd_neg);
    dvs_p0  <= fix_divisor(bus.divisor, dvs_neg);
    side_p0 <= side_in;
    tag_p0  <= bus.in_tag;
  end

  // ---- p1: DIVIDEND_W restoring-division steps ----
  logic                  vld_p1  [DIVIDEND_W+1];
  logic [DIVISOR_W-1:0]  rem_p1  [DIVIDEND_W+1];
  logic [DIVISOR_W-1:0]  dvs_p1  [DIVIDEND_W+1];
  logic [DIVIDEND_W-1:0] acc_p1  [DIVIDEND_W+1];
  side_t                 side_p1 [DIVIDEND_W+1];
  logic [TAG_W-1:0]      tag_p1  [DIVIDEND_W+1];

  assign vld_p1[0]  = vld_p0;
  assign rem_p1[0]  = '0;
  assign dvs_p1[0]  = dvs_p0;
  assign acc_p1[0]  = acc_p0;
  assign side_p1[0] = side_p0;
  assign tag_p1[0]  = tag_p0;

  for (genvar i = 0; i < DIVIDEND_W; i++) begin : g_stage
    divider_stage #(
      .DIVIDEND_W (DIVIDEND_W),
      .DIVISOR_W  (DIVISOR_W),
      .TAG_W      (TAG_W)
    ) u_stage (
      .clock    (clock),
      .reset    (reset),
      .vld_in   (vld_p1[i]),
      .rem_in   (rem_p1[i]),
      .dvs_in   (dvs_p1[i]),
      .acc_in   (acc_p1[i]),
      .side_in  (side_p1[i]),
      .tag_in   (tag_p1[i]),
      .vld_out  (vld_p1[i+1]),
      .rem_out  (rem_p1[i+1]),
      .dvs_out  (dvs_p1[i+1]),
      .acc_out  (acc_p1[i+1]),
      .side_out (side_p1[i+1]),
      .tag_out  (tag_p1[i+1])
    );
  end

  // ---- p2: sign fix and special-case override ----
  logic                  vld_p2;
  logic [DIVIDEND_W-1:0] q_mag_p2;
  logic [DIVISOR_W-1:0]  r_mag_p2;
  side_t                 side_p2;
  logic                  unused_p2;

  assign vld_p2    = vld_p1[DIVIDEND_W];
  assign q_mag_p2  = acc_p1[DIVIDEND_W];
  assign r_mag_p2  = rem_p1[DIVIDEND_W];
  assign side_p2   = side_p1[DIVIDEND_W];
  assign unused_p2 = side_p2.signed_mode ^ (^dvs_p1[DIVIDEND_W]);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.out_valid   <= 1'b0;
      bus.div_by_zero <= 1'b0;
      bus.overflow    <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.out_tag     <= '0;
    end else begin
      bus.out_valid   <= vld_p2;
      bus.div_by_zero <= vld_p2 & side_p2.div_by_zero;
      bus.overflow    <= vld_p2 & side_p2.overflow;
      if (vld_p2) begin
        bus.quotient  <= side_p2.div_by_zero ? '1 : fix_dividend(q_mag_p2, side_p2.neg_q);
        bus.remainder <= side_p2.div_by_zero ? '0 : fix_divisor(r_mag_p2, side_p2.neg_r);
        bus.out_tag   <= tag_p1[DIVIDEND_W];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_signed_divider.sv
// Scoreboard bench for pipelined_signed_divider at 8-bit dividend / 4-bit divisor.
module tb_pipelined_signed_divider;
  import pipelined_divider_pkg::*;

  localparam int DW  = 8;
  localparam int SW  = 4;
  localparam int TW  = 4;
  localparam int LAT = latency_of(DW);

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int            cyc;
    logic [DW-1:0] q;
    logic [SW-1:0] r;
    logic [TW-1:0] tag;
    logic          dbz;
    logic          ovf;
  } exp_t;

  exp_t sb[$];

  pipelined_signed_divider_if #(.DIVIDEND_W(DW), .DIVISOR_W(SW), .TAG_W(TW)) bus ();

  pipelined_signed_divider #(.DIVIDEND_W(DW), .DIVISOR_W(SW), .TAG_W(TW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer division, which truncates toward zero and keeps
  // the remainder's sign with the dividend.
  function automatic exp_t model(input bit sm, input logic [DW-1:0] a,
                                 input logic [SW-1:0] b, input logic [TW-1:0] tag);
    exp_t   e;
    longint num, den, lq, lr;
    e.cyc = 0; e.tag = tag; e.dbz = 1'b0; e.ovf = 1'b0;
    if (b == '0) begin
      e.q = '1; e.r = '0; e.dbz = 1'b1;
    end else begin
      if (sm) begin
        num   = longint'($signed(a));
        den   = longint'($signed(b));
        e.ovf = (num == -(longint'(1) <<< (DW-1))) && (den == -1);
      end else begin
        num = longint'(a);
        den = longint'(b);
      end
      lq  = num / den;
      lr  = num % den;
      e.q = lq[DW-1:0];
      e.r = lr[SW-1:0];
    end
    return e;
  endfunction

  function automatic exp_t mk(input logic [DW-1:0] q, input logic [SW-1:0] r,
                              input logic [TW-1:0] tag, input logic dbz, input logic ovf);
    exp_t e;
    e.cyc = 0; e.q = q; e.r = r; e.tag = tag; e.dbz = dbz; e.ovf = ovf;
    return e;
  endfunction

  task automatic issue(input bit sm, input logic [DW-1:0] a, input logic [SW-1:0] b,
                       input logic [TW-1:0] tag, input exp_t e);
    e.cyc = cyc + LAT;
    sb.push_back(e);
    bus.in_valid    = 1'b1;
    bus.signed_mode = sm;
    bus.dividend    = a;
    bus.divisor     = b;
    bus.in_tag      = tag;
    @(posedge clock); #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic issue_rand(input logic [TW-1:0] tag);
    bit            sm;
    logic [DW-1:0] a;
    logic [SW-1:0] b;
    sm = 1'($urandom_range(0, 1));
    a  = DW'($urandom);
    b  = SW'($urandom);
    if ($urandom_range(0, 7) == 0) b = '0;
    if ($urandom_range(0, 7) == 0) a = {1'b1, {(DW-1){1'b0}}};
    issue(sm, a, b, tag, model(sm, a, b, tag));
  endtask

  task automatic check_cleared(input string tag_name);
    chk({tag_name, "_out_valid"},   32'(bus.out_valid),   0);
    chk({tag_name, "_div_by_zero"}, 32'(bus.div_by_zero), 0);
    chk({tag_name, "_overflow"},    32'(bus.overflow),    0);
    chk({tag_name, "_quotient"},    32'(bus.quotient),    0);
    chk({tag_name, "_remainder"},   32'(bus.remainder),   0);
    chk({tag_name, "_out_tag"},     32'(bus.out_tag),     0);
  endtask

  // Monitor: pops the scoreboard whenever a result is presented.
  exp_t got;
  always @(negedge clock) begin
    if (!reset) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        n_cmp++;
        n_fail++;
        $display("FAIL missed_result: tag %0h due at cycle %0d, absent at cycle %0d",
                 sb[0].tag, sb[0].cyc, cyc);
        void'(sb.pop_front());
      end
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_output: out_valid=1 tag %0h, required nothing (cycle %0d)",
                   bus.out_tag, cyc);
        end else begin
          got = sb.pop_front();
          chk("latency_cycle", 32'(cyc),             32'(got.cyc));
          chk("tag",           32'(bus.out_tag),     32'(got.tag));
          chk("quotient",      32'(bus.quotient),    32'(got.q));
          chk("remainder",     32'(bus.remainder),   32'(got.r));
          chk("div_by_zero",   32'(bus.div_by_zero), 32'(got.dbz));
          chk("overflow",      32'(bus.overflow),    32'(got.ovf));
        end
      end else begin
        chk("idle_div_by_zero", 32'(bus.div_by_zero), 0);
        chk("idle_overflow",    32'(bus.overflow),    0);
      end
    end
  end

  initial begin
    bus.in_valid    = 1'b0;
    bus.signed_mode = 1'b0;
    bus.dividend    = '0;
    bus.divisor     = '0;
    bus.in_tag      = '0;
    repeat (3) @(posedge clock);
    #1;
    check_cleared("reset_state");
    reset = 1'b0;

    // Directed corner cases, first one on the very first edge after reset.
    issue(1'b0, 8'd200, 4'd7, 4'd1, mk(8'h1C, 4'h4, 4'd1, 1'b0, 1'b0));
    issue(1'b1, 8'hEF,  4'h2, 4'd2, mk(8'hF8, 4'hF, 4'd2, 1'b0, 1'b0));
    issue(1'b1, 8'h11,  4'hD, 4'd3, mk(8'hFB, 4'h2, 4'd3, 1'b0, 1'b0));
    issue(1'b1, 8'h80,  4'hF, 4'd4, mk(8'h80, 4'h0, 4'd4, 1'b0, 1'b1));
    issue(1'b0, 8'h80,  4'hF, 4'd5, mk(8'h08, 4'h8, 4'd5, 1'b0, 1'b0));
    issue(1'b0, 8'h5A,  4'h0, 4'd6, mk(8'hFF, 4'h0, 4'd6, 1'b1, 1'b0));
    issue(1'b1, 8'h80,  4'h0, 4'd7, mk(8'hFF, 4'h0, 4'd7, 1'b1, 1'b0));
    issue(1'b1, 8'h80,  4'h1, 4'd8, mk(8'h80, 4'h0, 4'd8, 1'b0, 1'b0));
    issue(1'b1, 8'h7F,  4'h8, 4'd9, mk(8'hF1, 4'h7, 4'd9, 1'b0, 1'b0));
    issue(1'b0, 8'hFF,  4'hF, 4'd10, mk(8'h11, 4'h0, 4'd10, 1'b0, 1'b0));
    idle(LAT + 2);

    // Twelve back-to-back random operations, tags 0..11.
    for (int t = 0; t < 12; t++) issue_rand(TW'(t));
    idle(LAT + 2);

    // Random operations with random gaps.
    for (int t = 0; t < 40; t++) begin
      issue_rand(TW'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(LAT + 2);

    // Reset while a result is on the outputs clears them with no clock edge.
    issue(1'b0, 8'd200, 4'd7, 4'd11, mk(8'h1C, 4'h4, 4'd11, 1'b0, 1'b0));
    idle(LAT - 1);
    chk("pre_reset_out_valid", 32'(bus.out_valid), 1);
    reset = 1'b1;
    sb.delete();
    #1;
    check_cleared("async_reset");
    @(posedge clock); #1;
    reset = 1'b0;
    idle(2);

    // In-flight operations are discarded by a one-cycle reset.
    for (int t = 0; t < 5; t++) issue_rand(TW'(t));
    reset = 1'b1;
    sb.delete();
    #1;
    chk("inflight_reset_out_valid", 32'(bus.out_valid), 0);
    @(posedge clock); #1;
    reset = 1'b0;
    issue(1'b1, 8'hEF, 4'h2, 4'd12, mk(8'hF8, 4'hF, 4'd12, 1'b0, 1'b0));
    idle(LAT + 4);

    for (int i = 0; i < LAT + 5 && sb.size() > 0; i++) @(posedge clock);
    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
